// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  typedef enum logic {
    GNT_IF = 1'b0,
    GNT_DM = 1'b1
  } grant_e;

  // Bits needed for a counter holding 0..max_val (LAT_CNT_W = cnt_w(MEM_LATENCY)).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_arb_grant.sv
// Priority pick between IF and DM with a starvation guard that forces IF to win
// once DM has been granted STARVE_LIMIT times in a row while IF was waiting.
module mem_arb_grant
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4,
  parameter int STARVE_W     = cnt_w(STARVE_LIMIT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic                dm_req,
  input  logic                arbitrate,
  output grant_e              grant,
  output logic [STARVE_W-1:0] starve_cnt
);

  localparam logic [STARVE_W-1:0] LIMIT = STARVE_W'(STARVE_LIMIT);

  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant = GNT_DM;
    if (!dm_req) begin
      grant = GNT_IF;
    end else if (if_req && (starve_cnt_q == LIMIT)) begin
      grant = GNT_IF;
    end
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (arbitrate && (if_req || dm_req)) begin
      if (grant == GNT_IF) begin
        starve_cnt_d = '0;
      end else if (if_req && (starve_cnt_q != LIMIT)) begin
        starve_cnt_d = starve_cnt_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt_q <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign starve_cnt = starve_cnt_q;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between IF and DM requesters.
// Optional performance counters are built when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  output logic              if_stall,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              dm_stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_dm_grants,
  output logic [31:0]       perf_stall_cycles
);

  localparam int LAT_CNT_W = cnt_w(MEM_LATENCY);
  localparam int STARVE_W  = cnt_w(STARVE_LIMIT);

  state_e                state_q, state_d;
  grant_e                gnt_q, gnt_d, arb_gnt;
  logic                  txn_we_q, txn_we_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic                  mem_en_q, mem_en_d, mem_we_q, mem_we_d;
  logic [ADDR_W-3:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0]     if_rdata_q, if_rdata_d, dm_rdata_q, dm_rdata_d;
  logic                  if_ready_q, if_ready_d, dm_ready_q, dm_ready_d;
  logic                  arbitrate, any_req;
  logic [STARVE_W-1:0]   starve_cnt;
  logic                  unused_ok;

  assign any_req   = if_req | dm_req;
  assign arbitrate = (state_q == IDLE);

  mem_arb_grant #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .STARVE_W     (STARVE_W)
  ) u_grant (
    .clk        (clk),
    .reset      (reset),
    .if_req     (if_req),
    .dm_req     (dm_req),
    .arbitrate  (arbitrate),
    .grant      (arb_gnt),
    .starve_cnt (starve_cnt)
  );

  // NOTE: the data registers are reset too, because abandoned transactions
  // must leave every output at zero after reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      gnt_q       <= GNT_IF;
      txn_we_q    <= 1'b0;
      lat_cnt_q   <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_ready_q  <= 1'b0;
      dm_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      txn_we_q    <= txn_we_d;
      lat_cnt_q   <= lat_cnt_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      dm_rdata_q  <= dm_rdata_d;
      if_ready_q  <= if_ready_d;
      dm_ready_q  <= dm_ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = WAIT;
      WAIT:    if (lat_cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_d       = gnt_q;
    txn_we_d    = txn_we_q;
    lat_cnt_d   = lat_cnt_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    dm_rdata_d  = dm_rdata_q;
    if_ready_d  = 1'b0;
    dm_ready_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d     = arb_gnt;
          lat_cnt_d = LAT_CNT_W'(MEM_LATENCY);
          mem_en_d  = 1'b1;
          if (arb_gnt == GNT_DM) begin
            txn_we_d    = dm_we;
            mem_we_d    = dm_we;
            mem_addr_d  = dm_addr[ADDR_W-1:2];
            mem_wdata_d = dm_wdata;
          end else begin
            txn_we_d    = 1'b0;
            mem_addr_d  = if_addr[ADDR_W-1:2];
            mem_wdata_d = '0;
          end
        end
      end
      // The counter hits zero in the cycle mem_rdata is valid for this access.
      WAIT: begin
        if (lat_cnt_q == '0) begin
          if (gnt_q == GNT_IF) begin
            if_rdata_d = mem_rdata;
            if_ready_d = 1'b1;
          end else begin
            if (!txn_we_q) dm_rdata_d = mem_rdata;
            dm_ready_d = 1'b1;
          end
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign if_ready  = if_ready_q;
  assign dm_ready  = dm_ready_q;
  assign if_stall  = if_req & ~if_ready_q;
  assign dm_stall  = dm_req & ~dm_ready_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_if_q, perf_if_d, perf_dm_q, perf_dm_d, perf_stall_q, perf_stall_d;

  always_comb begin
    perf_if_d    = perf_if_q;
    perf_dm_d    = perf_dm_q;
    perf_stall_d = perf_stall_q + {31'd0, (if_stall | dm_stall)};
    if (arbitrate && any_req) begin
      if (arb_gnt == GNT_DM) perf_dm_d = perf_dm_q + 32'd1;
      else                   perf_if_d = perf_if_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_if_q    <= '0;
      perf_dm_q    <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_if_q    <= perf_if_d;
      perf_dm_q    <= perf_dm_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_if_grants    = perf_if_q;
  assign perf_dm_grants    = perf_dm_q;
  assign perf_stall_cycles = perf_stall_q;
`else
  assign perf_if_grants    = '0;
  assign perf_dm_grants    = '0;
  assign perf_stall_cycles = '0;
`endif

  // Byte-offset bits are ignored by design; the starvation count is observational.
  assign unused_ok = ^{if_addr[1:0], dm_addr[1:0], starve_cnt};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-schedule reference model,
// directed scenarios with literal expectations, then randomized traffic with resets.
module tb_mem_port_arbiter;

  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MEM_LAT = 3;
  localparam int STARVE  = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_ready, if_stall;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              dm_req, dm_we, dm_ready, dm_stall;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata, dm_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [31:0]       perf_if_grants, perf_dm_grants, perf_stall_cycles;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LATENCY(MEM_LAT), .STARVE_LIMIT(STARVE)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .dm_stall(dm_stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .perf_if_grants(perf_if_grants), .perf_dm_grants(perf_dm_grants), .perf_stall_cycles(perf_stall_cycles)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Memory environment: sparse backing store with a deterministic fill pattern.
  logic [DATA_W-1:0] mem_arr [logic [29:0]];

  function automatic logic [31:0] mem_rd(input logic [29:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return ({2'b00, a} * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  int          rd_due = -1;
  logic [29:0] rd_addr = '0;

  // Read data is valid only in the cycle exactly MEM_LAT after mem_en; junk otherwise.
  initial begin
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (rd_due == cyc) mem_rdata = mem_rd(rd_addr);
      else               mem_rdata = $urandom;
      if (mem_en && !mem_we) begin
        rd_due  = cyc + MEM_LAT;
        rd_addr = mem_addr;
      end
      if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    end
  end

  // Requesters: hold until ready, then drop or immediately present the next request.
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  req_t if_q[$];
  req_t dm_q[$];
  bit   rand_on = 1'b0;
  int   last_if_raise = 0;
  int   last_dm_raise = 0;

  function automatic bit pick(input bit is_dm, output req_t r);
    r = '0;
    if (!is_dm && if_q.size() > 0) begin r = if_q.pop_front(); return 1'b1; end
    if (is_dm && dm_q.size() > 0)  begin r = dm_q.pop_front(); return 1'b1; end
    if (rand_on && $urandom_range(0, 3) != 0) begin
      r.we    = is_dm ? 1'($urandom_range(0, 1)) : 1'b0;
      r.addr  = {24'd0, 6'($urandom_range(0, 31)), 2'($urandom_range(0, 3))};
      r.wdata = $urandom;
      return 1'b1;
    end
    return 1'b0;
  endfunction

  initial begin
    bit   r_if, r_dm;
    req_t r;
    if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0;
    forever begin
      @(negedge clk);
      r_if = if_ready;
      r_dm = dm_ready;
      @(posedge clk);
      #1;
      if (r_if || !if_req) begin
        if_req = 1'b0;
        if (pick(1'b0, r)) begin
          if_req = 1'b1; if_addr = r.addr; last_if_raise = cyc;
        end
      end
      if (r_dm || !dm_req) begin
        dm_req = 1'b0;
        if (pick(1'b1, r)) begin
          dm_req = 1'b1; dm_we = r.we; dm_addr = r.addr; dm_wdata = r.wdata; last_dm_raise = cyc;
        end
      end
    end
  end

  // Reference model: each grant fixes mem_en at +1, ready at +MEM_LAT+2 and the
  // next arbitration opportunity at +MEM_LAT+3.
  bit          chk_on = 1'b0;
  bit          post_reset = 1'b0;
  int          free_at = 0, en_cyc = -1, rdy_cyc = -1, starve = 0;
  bit          g_dm = 1'b0, g_we = 1'b0;
  logic [29:0] g_addr = '0;
  logic [31:0] g_wdata = '0, g_rdata = '0;
  logic [31:0] exp_if_rdata = '0, exp_dm_rdata = '0;
  logic [31:0] m_if = '0, m_dm = '0, m_stall = '0;

  initial begin
    bit e_en, e_ifr, e_dmr, e_ifs, e_dms;
    forever begin
      @(negedge clk);
      e_en  = (cyc == en_cyc);
      e_ifr = (cyc == rdy_cyc) && !g_dm;
      e_dmr = (cyc == rdy_cyc) && g_dm;
      e_ifs = if_req && !e_ifr;
      e_dms = dm_req && !e_dmr;
      if (chk_on) begin
        if (e_ifr) exp_if_rdata = g_rdata;
        if (e_dmr && !g_we) exp_dm_rdata = g_rdata;
        check("mem_en", mem_en, e_en);
        check("mem_we", mem_we, e_en && g_we);
        if (e_en) check("mem_addr", mem_addr, g_addr);
        if (e_en && g_we) check("mem_wdata", mem_wdata, g_wdata);
        if (post_reset) begin
          check("mem_addr_rst", mem_addr, 0);
          check("mem_wdata_rst", mem_wdata, 0);
        end
        check("if_ready", if_ready, e_ifr);
        check("dm_ready", dm_ready, e_dmr);
        check("if_rdata", if_rdata, exp_if_rdata);
        check("dm_rdata", dm_rdata, exp_dm_rdata);
        check("if_stall", if_stall, e_ifs);
        check("dm_stall", dm_stall, e_dms);
`ifdef MEM_ARB_PERF_EN
        check("perf_if_grants", perf_if_grants, m_if);
        check("perf_dm_grants", perf_dm_grants, m_dm);
        check("perf_stall_cycles", perf_stall_cycles, m_stall);
`else
        check("perf_if_grants", perf_if_grants, 0);
        check("perf_dm_grants", perf_dm_grants, 0);
        check("perf_stall_cycles", perf_stall_cycles, 0);
`endif
      end
      if (!reset) begin
        chk_on = 1'b1; post_reset = 1'b1;
        en_cyc = -1; rdy_cyc = -1; free_at = cyc + 1; starve = 0;
        exp_if_rdata = '0; exp_dm_rdata = '0;
        m_if = '0; m_dm = '0; m_stall = '0;
      end else if (chk_on) begin
        post_reset = 1'b0;
        if (e_ifs || e_dms) m_stall = m_stall + 32'd1;
        if (cyc >= free_at && (if_req || dm_req)) begin
          g_dm = dm_req && !(if_req && starve == STARVE);
          if (g_dm) begin
            if (if_req && starve < STARVE) starve++;
            g_we = dm_we; g_addr = dm_addr[31:2]; g_wdata = dm_wdata; m_dm = m_dm + 32'd1;
          end else begin
            starve = 0;
            g_we = 1'b0; g_addr = if_addr[31:2]; g_wdata = '0; m_if = m_if + 32'd1;
          end
          g_rdata = mem_rd(g_addr);
          en_cyc  = cyc + 1;
          rdy_cyc = cyc + MEM_LAT + 2;
          free_at = cyc + MEM_LAT + 3;
        end
      end
    end
  end

  // Grant order as seen on the memory side.
  bit          log_on = 1'b0;
  logic [29:0] gnt_log[$];

  initial begin
    forever begin
      @(negedge clk);
      if (log_on && mem_en) gnt_log.push_back(mem_addr);
    end
  end

  task automatic at_cyc(input int t);
    do @(negedge clk); while (cyc < t);
    if (cyc != t) check("at_cyc_overshoot", cyc, t);
  endtask

  task automatic wait_raise(input bit is_dm, output int t);
    t = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (is_dm ? dm_req : if_req) begin
        t = is_dm ? last_dm_raise : last_if_raise;
        return;
      end
    end
    check("wait_raise_timeout", 1, 0);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!if_req && !dm_req && if_q.size() == 0 && dm_q.size() == 0) return;
    end
    check("wait_idle_timeout", 1, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int    t;
    string pat;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_mem_en", mem_en, 0);
    check("rst_if_ready", if_ready, 0);
    check("rst_dm_rdata", dm_rdata, 0);
    check("rst_mem_addr", mem_addr, 0);

    // IF fetch from 0x40.
    mem_arr[30'h10] = 32'h2001_0005;
    if_q.push_back('{we: 1'b0, addr: 32'h0000_0040, wdata: 32'h0});
    wait_raise(1'b0, t);
    check("t1_stall_c0", if_stall, 1);
    at_cyc(t + 1);
    check("t1_mem_en", mem_en, 1);
    check("t1_mem_addr", mem_addr, 30'h10);
    check("t1_mem_we", mem_we, 0);
    at_cyc(t + MEM_LAT + 1);
    check("t1_stall_wait", if_stall, 1);
    check("t1_not_ready_yet", if_ready, 0);
    at_cyc(t + MEM_LAT + 2);
    check("t1_if_ready", if_ready, 1);
    check("t1_if_rdata", if_rdata, 32'h2001_0005);
    check("t1_stall_done", if_stall, 0);
    wait_idle(100);

    // Simultaneous IF and DM: DM first, IF spaced MEM_LAT+3 behind.
    mem_arr[30'h40] = 32'hCAFE_0100;
    if_q.push_back('{we: 1'b0, addr: 32'h0000_0080, wdata: 32'h0});
    dm_q.push_back('{we: 1'b0, addr: 32'h0000_0100, wdata: 32'h0});
    wait_raise(1'b1, t);
    at_cyc(t + 1);
    check("t2_dm_first_en", mem_en, 1);
    check("t2_dm_first_addr", mem_addr, 30'h40);
    at_cyc(t + MEM_LAT + 2);
    check("t2_dm_rdata", dm_rdata, 32'hCAFE_0100);
    at_cyc(t + 1 + MEM_LAT + 3);
    check("t2_if_en", mem_en, 1);
    check("t2_if_addr", mem_addr, 30'h20);
    wait_idle(100);

    // DM write leaves dm_rdata untouched.
    dm_q.push_back('{we: 1'b1, addr: 32'h0000_0008, wdata: 32'hDEAD_BEEF});
    wait_raise(1'b1, t);
    at_cyc(t + 1);
    check("t3_mem_en", mem_en, 1);
    check("t3_mem_we", mem_we, 1);
    check("t3_mem_addr", mem_addr, 30'h2);
    check("t3_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    at_cyc(t + MEM_LAT + 2);
    check("t3_dm_ready", dm_ready, 1);
    check("t3_dm_rdata_kept", dm_rdata, 32'hCAFE_0100);
    wait_idle(100);

    // Starvation guard: both held continuously.
    gnt_log.delete();
    log_on = 1'b1;
    for (int i = 0; i < 6; i++) dm_q.push_back('{we: 1'b0, addr: 32'h1000 + 32'(4 * i), wdata: 32'h0});
    for (int i = 0; i < 2; i++) if_q.push_back('{we: 1'b0, addr: 32'h3000 + 32'(4 * i), wdata: 32'h0});
    wait_idle(400);
    log_on = 1'b0;
    pat = "DDDDIDDI";
    check("t4_grant_count", gnt_log.size(), 8);
    for (int i = 0; i < 8 && i < gnt_log.size(); i++)
      check($sformatf("t4_grant_%0d_is_dm", i), gnt_log[i] < 30'h800, pat[i] == "D");

    // Reset during WAIT abandons the access; the held request is re-served.
    mem_arr[30'h80] = 32'h1234_5678;
    dm_q.push_back('{we: 1'b0, addr: 32'h0000_0200, wdata: 32'h0});
    wait_raise(1'b1, t);
    at_cyc(t + 1);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    at_cyc(t + 3);
    check("t5_rst_mem_en", mem_en, 0);
    check("t5_rst_dm_ready", dm_ready, 0);
    check("t5_rst_mem_addr", mem_addr, 0);
    check("t5_rst_dm_rdata", dm_rdata, 0);
    check("t5_req_held", dm_req, 1);
    at_cyc(t + MEM_LAT + 2);
    check("t5_no_ready_abandoned", dm_ready, 0);
    at_cyc(t + 3 + MEM_LAT + 2);
    check("t5_ready_after_rst", dm_ready, 1);
    check("t5_rdata_after_rst", dm_rdata, 32'h1234_5678);
    wait_idle(100);

    // Counter scenario: 2 IF + 3 DM from a fresh reset.
    pulse_reset();
    if_q.push_back('{we: 1'b0, addr: 32'h40, wdata: 32'h0});
    if_q.push_back('{we: 1'b0, addr: 32'h44, wdata: 32'h0});
    dm_q.push_back('{we: 1'b1, addr: 32'h20, wdata: 32'h0BAD_F00D});
    dm_q.push_back('{we: 1'b0, addr: 32'h20, wdata: 32'h0});
    dm_q.push_back('{we: 1'b0, addr: 32'h24, wdata: 32'h0});
    wait_idle(200);
    @(negedge clk);
`ifdef MEM_ARB_PERF_EN
    check("t6_perf_if", perf_if_grants, 2);
    check("t6_perf_dm", perf_dm_grants, 3);
    check("t6_perf_stall", perf_stall_cycles, m_stall);
`else
    check("t6_perf_if_off", perf_if_grants, 0);
    check("t6_perf_dm_off", perf_dm_grants, 0);
`endif

    // Random traffic with occasional resets.
    rand_on = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      reset = ($urandom_range(0, 399) != 0);
    end
    reset = 1'b1;
    rand_on = 1'b0;
    wait_idle(300);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
